// File: rtl/cmp_serial_arbiter.sv
// ---------------------------------------------------------------------------
// cmp_serial_arbiter
//
// Purpose:
//   Shares one bit-serial unsigned magnitude comparator among NREQ requesters.
//   A round-robin arbiter picks a winner. Its operands are captured and then
//   compared MSB-first, one bit-slice per cycle. The gt/eq/lt result is
//   returned tagged with the winner's id.
//
// Optional feature (macro CMP_EARLY_EXIT_EN):
//   defined   : COMPARE stops at the first differing bit (data-dependent latency).
//   undefined : all WIDTH bits are always walked and the first decision is held
//               in flags (fixed latency WIDTH+1). Both modes give the same results.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [NREQ]        per-requester request level
//   a_in     in   [NREQ*WIDTH]  operand A, requester r at [r*WIDTH +: WIDTH]
//   b_in     in   [NREQ*WIDTH]  operand B, same packing
//   gnt      out  [NREQ]        one-hot, one-cycle grant pulse
//   busy     out  1             high whenever not idle
//   done     out  1             one-cycle result-valid pulse
//   done_id  out  [IDW]         id owning the result on gt/eq/lt
//   gt/eq/lt out  1             unsigned A>B / A==B / A<B, held until next grant
// ---------------------------------------------------------------------------
module cmp_serial_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic                    gt,
  output logic                    eq,
  output logic                    lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   rrPtr;
  logic [IDW-1:0]   winId;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [IW-1:0]    bitIdx;

  // Single-bit slice presented to the comparator cell; one slice per cycle.
  logic             sliceA_p0;
  logic             sliceB_p0;
  logic             vld_p0;
  logic             last_p0;

`ifndef CMP_EARLY_EXIT_EN
  logic             decided;
  logic             flagGt;
  logic             flagLt;
`endif

  logic [IDW-1:0]   searchPtr;
  logic [IDW-1:0]   winNext;
  logic             grantEn;
  logic             curGt;
  logic             curLt;
  logic             finishNow;
  logic             resGt;
  logic             resLt;
  logic             resEq;

  // First requester at or after ptr, wrapping. NREQ is a power of two, so
  // IDW-bit addition wraps naturally.
  function automatic logic [IDW-1:0] pickWinner(input logic [NREQ-1:0] r,
                                                input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] cand;
    logic           found;
    pickWinner = ptr;
    found      = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ptr + IDW'(off);
      if (!found && r[cand]) begin
        pickWinner = cand;
        found      = 1'b1;
      end
    end
  endfunction

  // Arbitration: a new grant may be issued from IDLE or on the edge that
  // leaves DONE. In DONE the pointer update is still pending, so search from
  // the value it is about to take.
  always_comb begin
    searchPtr = (state == DONE) ? (winId + IDW'(1)) : rrPtr;
    winNext   = pickWinner(req, searchPtr);
    grantEn   = ((state == IDLE) || (state == DONE)) && (|req);
  end

  // Decision from the slice currently held in the comparator cell.
  always_comb begin
    curGt = sliceA_p0 & ~sliceB_p0;
    curLt = ~sliceA_p0 & sliceB_p0;
`ifdef CMP_EARLY_EXIT_EN
    finishNow = vld_p0 && (curGt || curLt || last_p0);
    resGt     = curGt;
    resLt     = curLt;
`else
    finishNow = vld_p0 && last_p0;
    resGt     = decided ? flagGt : curGt;
    resLt     = decided ? flagLt : curLt;
`endif
    resEq = ~(resGt | resLt);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      winId     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      bitIdx    <= '0;
      sliceA_p0 <= 1'b0;
      sliceB_p0 <= 1'b0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      decided   <= 1'b0;
      flagGt    <= 1'b0;
      flagLt    <= 1'b0;
`endif
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            rrPtr <= winId + IDW'(1);
          end
          if (grantEn) begin
            // --- grant / operand capture ---
            state     <= COMPARE;
            winId     <= winNext;
            aReg      <= a_in[int'(winNext)*WIDTH +: WIDTH];
            bReg      <= b_in[int'(winNext)*WIDTH +: WIDTH];
            gnt       <= NREQ'(1) << winNext;
            bitIdx    <= IW'(WIDTH - 1);
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            decided   <= 1'b0;
            flagGt    <= 1'b0;
            flagLt    <= 1'b0;
`endif
            done_id   <= '0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        COMPARE: begin
          if (finishNow) begin
            // --- result presentation ---
            state   <= DONE;
            done    <= 1'b1;
            done_id <= winId;
            gt      <= resGt;
            eq      <= resEq;
            lt      <= resLt;
          end else begin
`ifndef CMP_EARLY_EXIT_EN
            if (vld_p0 && !decided && (curGt || curLt)) begin
              decided <= 1'b1;
              flagGt  <= curGt;
              flagLt  <= curLt;
            end
`endif
            // --- next bit-slice load (stops once bit 0 is in the cell) ---
            if (!(vld_p0 && last_p0)) begin
              sliceA_p0 <= aReg[bitIdx];
              sliceB_p0 <= bReg[bitIdx];
              vld_p0    <= 1'b1;
              last_p0   <= (bitIdx == '0);
              if (bitIdx != '0) begin
                bitIdx <= bitIdx - IW'(1);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_serial_arbiter.sv
module tb_cmp_serial_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

`ifdef CMP_EARLY_EXIT_EN
  localparam int LAT_MSB = 2;
`else
  localparam int LAT_MSB = 9;
`endif
  localparam int LAT_FULL = 9;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  gt, eq, lt;

  cmp_serial_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chkEn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Latency from grant to done = bits examined + 1.
  function automatic int expLat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--)
      if (a[i] != b[i]) return (WIDTH - i) + 1;
    return WIDTH + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  logic             mActive;
  int               mCnt, mLat, mPtr, mWin;
  logic [WIDTH-1:0] mA, mB;
  logic [NREQ-1:0]  eGnt;
  logic             eBusy, eDone, eGt, eEq, eLt;
  logic [IDW-1:0]   eId;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0; mCnt <= 0; mLat <= 0; mPtr <= 0; mWin <= 0;
      mA <= '0; mB <= '0;
      eGnt <= '0; eBusy <= 1'b0; eDone <= 1'b0; eId <= '0;
      eGt <= 1'b0; eEq <= 1'b0; eLt <= 1'b0;
    end else begin
      automatic logic act = mActive;
      automatic int cnt = mCnt;
      automatic int lat = mLat;
      automatic int ptr = mPtr;
      automatic int win = mWin;
      automatic logic [WIDTH-1:0] a = mA;
      automatic logic [WIDTH-1:0] b = mB;
      automatic logic [NREQ-1:0] nGnt = '0;
      automatic logic nDone = 1'b0;
      automatic logic [IDW-1:0] nId = eId;
      automatic logic nGt = eGt;
      automatic logic nEq = eEq;
      automatic logic nLt = eLt;
      automatic logic canG = !mActive;
      if (act) begin
        cnt = cnt + 1;
        if (cnt == lat) begin
          nDone = 1'b1; nId = IDW'(win);
          nGt = (a > b); nEq = (a == b); nLt = (a < b);
        end else if (cnt == lat + 1) begin
          act = 1'b0; ptr = (win + 1) % NREQ; canG = 1'b1;
        end
      end
      if (canG && req != '0) begin
        for (int off = NREQ - 1; off >= 0; off--)
          if (req[(ptr + off) % NREQ]) win = (ptr + off) % NREQ;
        a = a_in[win*WIDTH +: WIDTH];
        b = b_in[win*WIDTH +: WIDTH];
        lat = expLat(a, b);
        act = 1'b1; cnt = 0;
        nGnt = NREQ'(1) << win;
        nId = '0; nGt = 1'b0; nEq = 1'b0; nLt = 1'b0;
      end
      mActive <= act; mCnt <= cnt; mLat <= lat; mPtr <= ptr; mWin <= win;
      mA <= a; mB <= b;
      eGnt <= nGnt; eBusy <= act; eDone <= nDone; eId <= nId;
      eGt <= nGt; eEq <= nEq; eLt <= nLt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chkEn) begin
      check("gnt", gnt, eGnt);
      check("busy", busy, eBusy);
      check("done", done, eDone);
      check("done_id", done_id, eId);
      check("gt", gt, eGt);
      check("eq", eq, eEq);
      check("lt", lt, eLt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setOps(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[id*WIDTH +: WIDTH] = a;
    b_in[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic waitAnyGnt(output int gid, output int gc, output logic [NREQ-1:0] gv);
    gid = -1; gc = -1; gv = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        gc = cyc; gv = gnt;
        for (int r = 0; r < NREQ; r++) if (gnt[r]) gid = r;
        return;
      end
    end
    check("gntTimeout", 0, 1);
  endtask

  task automatic waitDone(output int dc);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; return; end
    end
    check("doneTimeout", 0, 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_doneId"}, done_id, 0);
    check({tag, "_res"}, {gt, eq, lt}, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int gid, gc, dc;
  logic [NREQ-1:0] gv;
  int order[5];
  int expOrder[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) @(negedge clk);
    checkIdleOutputs("rst0");
    rst_n = 1'b1;
    chkEn = 1'b1;

    // Single request, MSB differs
    @(negedge clk);
    setOps(2, 8'hA5, 8'h25);
    req[2] = 1'b1;
    waitAnyGnt(gid, gc, gv);
    req[2] = 1'b0;
    check("single_gnt", gv, 4'b0100);
    waitDone(dc);
    check("single_res", {gt, eq, lt}, 3'b100);
    check("single_id", done_id, 2);
    check("single_lat", dc - gc, LAT_MSB);

    // Equal operands
    @(negedge clk);
    setOps(1, 8'h3C, 8'h3C);
    req[1] = 1'b1;
    waitAnyGnt(gid, gc, gv);
    req[1] = 1'b0;
    check("equal_gnt", gv, 4'b0010);
    waitDone(dc);
    check("equal_res", {gt, eq, lt}, 3'b010);
    check("equal_lat", dc - gc, LAT_FULL);

    // Late difference, then result hold
    @(negedge clk);
    setOps(3, 8'h00, 8'h01);
    req[3] = 1'b1;
    waitAnyGnt(gid, gc, gv);
    req[3] = 1'b0;
    waitDone(dc);
    check("late_res", {gt, eq, lt}, 3'b001);
    check("late_id", done_id, 3);
    check("late_lat", dc - gc, LAT_FULL);
    repeat (5) @(negedge clk);
    check("hold_res", {gt, eq, lt}, 3'b001);
    check("hold_id", done_id, 3);
    check("hold_done", done, 0);

    // Operand change after grant is ignored
    @(negedge clk);
    setOps(0, 8'h80, 8'h40);
    req[0] = 1'b1;
    waitAnyGnt(gid, gc, gv);
    setOps(0, 8'h00, 8'h40);
    req[0] = 1'b0;
    waitDone(dc);
    check("ophold_res", {gt, eq, lt}, 3'b100);
    check("ophold_lat", dc - gc, LAT_MSB);

    // Reset mid-COMPARE (pointer is 1 here, so id 1 wins first)
    @(negedge clk);
    setOps(0, 8'h3C, 8'h3C);
    setOps(1, 8'h3C, 8'h3C);
    req = 4'b0011;
    waitAnyGnt(gid, gc, gv);
    check("abort_firstWin", gid, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("rstMid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitAnyGnt(gid, gc, gv);
    check("abort_postGnt", gv, 4'b0001);
    req[0] = 1'b0;
    waitDone(dc);
    check("abort_doneId", done_id, 0);
    waitAnyGnt(gid, gc, gv);
    check("abort_nextGnt", gv, 4'b0010);
    req[1] = 1'b0;
    waitDone(dc);
    check("abort_doneId2", done_id, 1);

    // Round-robin with all requesters active
    doReset();
    for (int r = 0; r < NREQ; r++) setOps(r, 8'(r + 1), 8'h80);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitAnyGnt(gid, gc, gv);
      order[n] = gid;
      check("rr_onehot", $onehot(gv), 1);
      if (gid >= 0) req[gid] = 1'b0;
      @(negedge clk);
      if (gid >= 0) req[gid] = 1'b1;
    end
    for (int n = 0; n < 5; n++) check($sformatf("rr_order%0d", n), order[n], expOrder[n]);
    req = '0;
    repeat (25) @(negedge clk);
    check("rr_drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
